// File: rtl/fwrisc_regfile_dbg_pkg.sv
// fwrisc_regfile_dbg_pkg: shared constants and arbiter state type for the regfile debug arbiter
package fwrisc_regfile_dbg_pkg;
  localparam int REGFILE_AW = 6;
  localparam int REGFILE_DW = 32;
  localparam int GPR_LAST = 31;
  typedef enum logic [2:0] {IDLE, HOLD, RD_ADDR, RD_DATA, WR, ACK} dbg_arb_state_e;
endpackage

// File: rtl/fwrisc_regfile_dbg_timeout.sv
// fwrisc_regfile_dbg_timeout: cycle counter flagging when HOLD has waited HOLD_TIMEOUT cycles
module fwrisc_regfile_dbg_timeout
  import fwrisc_regfile_dbg_pkg::*;
#(
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(HOLD_TIMEOUT);
  logic [CW-1:0] count;
  always_ff @(posedge clock)
    if (!reset || clear) count <= '0;
    else if (en) count <= count + CW'(1);
  assign expired = count == CW'(HOLD_TIMEOUT - 1);
endmodule

// File: rtl/fwrisc_regfile_dbg_arb.sv
// fwrisc_regfile_dbg_arb: shares the regfile between core and debug port; FWRISC_REGFILE_DBG_CSR_EN opens CSR shadow 32-63 to debug
module fwrisc_regfile_dbg_arb
  import fwrisc_regfile_dbg_pkg::*;
#(
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REGFILE_AW-1:0] core_ra_raddr,
  input  logic [REGFILE_AW-1:0] core_rb_raddr,
  input  logic [REGFILE_AW-1:0] core_rd_waddr,
  input  logic [REGFILE_DW-1:0] core_rd_wdata,
  input  logic                  core_rd_wen,
  input  logic                  core_quiesce,
  output logic                  core_hold,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [REGFILE_AW-1:0] dbg_addr,
  input  logic [REGFILE_DW-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic                  dbg_err,
  output logic [REGFILE_DW-1:0] dbg_rdata,
  output logic [REGFILE_AW-1:0] rf_ra_raddr,
  output logic [REGFILE_AW-1:0] rf_rb_raddr,
  output logic [REGFILE_AW-1:0] rf_rd_waddr,
  output logic [REGFILE_DW-1:0] rf_rd_wdata,
  output logic                  rf_rd_wen,
  input  logic [REGFILE_DW-1:0] rf_ra_rdata
);
  dbg_arb_state_e state, state_nxt;
  logic expired, illegal, grant, pass;
  fwrisc_regfile_dbg_timeout #(.HOLD_TIMEOUT(HOLD_TIMEOUT)) u_timeout (
    .clock(clock),
    .reset(reset),
    .clear(state == IDLE),
    .en(state == HOLD),
    .expired(expired)
  );
`ifdef FWRISC_REGFILE_DBG_CSR_EN
  assign illegal = 1'b0;
`else
  assign illegal = dbg_addr > REGFILE_AW'(GPR_LAST);
`endif
  assign grant = core_quiesce && !core_rd_wen;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = dbg_req ? HOLD : IDLE;
      HOLD:    state_nxt = illegal ? ACK : grant ? (dbg_we ? WR : RD_ADDR) : expired ? ACK : HOLD;
      RD_ADDR: state_nxt = RD_DATA;
      RD_DATA: state_nxt = ACK;
      WR:      state_nxt = ACK;
      ACK:     state_nxt = dbg_req ? ACK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (!reset) begin
      state     <= IDLE;
      dbg_rdata <= '0;
      dbg_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RD_DATA) dbg_rdata <= rf_ra_rdata;
      if (state == RD_DATA || state == WR) dbg_err <= 1'b0;
      else if (state == HOLD && state_nxt == ACK) dbg_err <= 1'b1;
    end
  // Core signals pass only while the core may still be draining (IDLE/HOLD)
  assign pass        = state == IDLE || state == HOLD;
  assign core_hold   = state != IDLE;
  assign dbg_ack     = state == ACK;
  assign rf_ra_raddr = (state == RD_ADDR || state == RD_DATA) ? dbg_addr : core_ra_raddr;
  assign rf_rb_raddr = core_rb_raddr;
  assign rf_rd_waddr = state == WR ? dbg_addr : core_rd_waddr;
  assign rf_rd_wdata = state == WR ? dbg_wdata : core_rd_wdata;
  assign rf_rd_wen   = state == WR ? dbg_addr != '0 : pass && core_rd_wen;
endmodule

// File: tb/tb_fwrisc_regfile_dbg_arb.sv
// tb_fwrisc_regfile_dbg_arb: directed bench with a behavioural regfile (registered read address, x0 forced to 0)
module tb_fwrisc_regfile_dbg_arb;
  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  core_ra_raddr, core_rb_raddr, core_rd_waddr;
  logic [31:0] core_rd_wdata;
  logic        core_rd_wen, core_quiesce, core_hold;
  logic        dbg_req, dbg_we, dbg_ack, dbg_err;
  logic [5:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic [5:0]  rf_ra_raddr, rf_rb_raddr, rf_rd_waddr;
  logic [31:0] rf_rd_wdata, rf_ra_rdata;
  logic        rf_rd_wen;
  int checks = 0;
  int failures = 0;
  int wen_cnt = 0;
  int w0;
  logic [31:0] mem [64];
  logic [5:0]  ra_q = '0;

  always #5 clock = ~clock;

  fwrisc_regfile_dbg_arb #(.HOLD_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .core_ra_raddr(core_ra_raddr), .core_rb_raddr(core_rb_raddr),
    .core_rd_waddr(core_rd_waddr), .core_rd_wdata(core_rd_wdata),
    .core_rd_wen(core_rd_wen), .core_quiesce(core_quiesce), .core_hold(core_hold),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .rf_ra_raddr(rf_ra_raddr), .rf_rb_raddr(rf_rb_raddr),
    .rf_rd_waddr(rf_rd_waddr), .rf_rd_wdata(rf_rd_wdata),
    .rf_rd_wen(rf_rd_wen), .rf_ra_rdata(rf_ra_rdata)
  );

  always @(posedge clock) begin
    ra_q <= rf_ra_raddr;
    if (rf_rd_wen === 1'b1 && rf_rd_waddr != 6'd0) mem[rf_rd_waddr] <= rf_rd_wdata;
  end
  assign rf_ra_rdata = ra_q == 6'd0 ? 32'd0 : mem[ra_q];

  always @(posedge clock) if (rf_rd_wen === 1'b1) wen_cnt = wen_cnt + 1;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    core_ra_raddr = 6'd3; core_rb_raddr = 6'd4; core_rd_waddr = 6'd0;
    core_rd_wdata = '0; core_rd_wen = 1'b0; core_quiesce = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    tick(2);
    chk("rst_hold", 32'(core_hold), 32'd0);
    chk("rst_ack", 32'(dbg_ack), 32'd0);
    chk("rst_err", 32'(dbg_err), 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    chk("idle_ra_pass", 32'(rf_ra_raddr), 32'd3);
    chk("rb_pass", 32'(rf_rb_raddr), 32'd4);
    reset = 1'b1;
    core_quiesce = 1'b1;
    tick();
    // debug write x5
    w0 = wen_cnt;
    dbg_we = 1'b1; dbg_addr = 6'd5; dbg_wdata = 32'hDEADBEEF; dbg_req = 1'b1;
    tick();
    chk("wr_c1_hold", 32'(core_hold), 32'd1);
    chk("wr_c1_wen", 32'(rf_rd_wen), 32'd0);
    tick();
    chk("wr_c2_wen", 32'(rf_rd_wen), 32'd1);
    chk("wr_c2_waddr", 32'(rf_rd_waddr), 32'd5);
    chk("wr_c2_wdata", rf_rd_wdata, 32'hDEADBEEF);
    tick();
    chk("wr_c3_ack", 32'(dbg_ack), 32'd1);
    chk("wr_c3_err", 32'(dbg_err), 32'd0);
    chk("wr_c3_wen", 32'(rf_rd_wen), 32'd0);
    dbg_req = 1'b0;
    tick();
    chk("wr_rel_hold", 32'(core_hold), 32'd0);
    chk("wr_rel_ack", 32'(dbg_ack), 32'd0);
    chk("wr_wen_count", 32'(wen_cnt - w0), 32'd1);
    // debug read x5
    dbg_we = 1'b0; dbg_req = 1'b1;
    tick(2);
    chk("rd_c2_raddr", 32'(rf_ra_raddr), 32'd5);
    tick();
    chk("rd_c3_ack", 32'(dbg_ack), 32'd0);
    tick();
    chk("rd_c4_ack", 32'(dbg_ack), 32'd1);
    chk("rd_c4_rdata", dbg_rdata, 32'hDEADBEEF);
    dbg_req = 1'b0;
    tick();
    // debug write x0 must not write
    w0 = wen_cnt;
    dbg_we = 1'b1; dbg_addr = 6'd0; dbg_wdata = 32'h1234; dbg_req = 1'b1;
    tick(3);
    chk("wx0_ack", 32'(dbg_ack), 32'd1);
    dbg_req = 1'b0;
    tick();
    chk("wx0_no_wen", 32'(wen_cnt - w0), 32'd0);
    dbg_we = 1'b0; dbg_req = 1'b1;
    tick(4);
    chk("rx0_ack", 32'(dbg_ack), 32'd1);
    chk("rx0_rdata", dbg_rdata, 32'd0);
    dbg_req = 1'b0;
    tick();
    // core write drains during HOLD
    core_rd_waddr = 6'd7; core_rd_wdata = 32'h11; core_rd_wen = 1'b1;
    dbg_we = 1'b0; dbg_addr = 6'd7; dbg_req = 1'b1;
    tick(2);
    chk("drain_c2_hold", 32'(core_hold), 32'd1);
    chk("drain_c2_wen", 32'(rf_rd_wen), 32'd1);
    chk("drain_c2_waddr", 32'(rf_rd_waddr), 32'd7);
    tick();
    core_rd_wen = 1'b0;
    chk("drain_c3_nogrant", 32'(rf_ra_raddr), 32'd3);
    tick(2);
    chk("drain_c5_ack", 32'(dbg_ack), 32'd0);
    tick();
    chk("drain_c6_ack", 32'(dbg_ack), 32'd1);
    chk("drain_rdata", dbg_rdata, 32'h11);
    dbg_req = 1'b0;
    tick();
    // timeout with quiesce stuck low
    core_quiesce = 1'b0;
    w0 = wen_cnt;
    dbg_we = 1'b1; dbg_addr = 6'd9; dbg_wdata = 32'h99; dbg_req = 1'b1;
    tick(8);
    chk("to_c8_ack", 32'(dbg_ack), 32'd0);
    tick();
    chk("to_c9_ack", 32'(dbg_ack), 32'd1);
    chk("to_c9_err", 32'(dbg_err), 32'd1);
    dbg_req = 1'b0;
    tick();
    chk("to_no_wen", 32'(wen_cnt - w0), 32'd0);
    core_quiesce = 1'b1;
    // CSR shadow address
    w0 = wen_cnt;
    dbg_we = 1'b1; dbg_addr = 6'h21; dbg_wdata = 32'h5; dbg_req = 1'b1;
    tick(2);
`ifdef FWRISC_REGFILE_DBG_CSR_EN
    chk("csr_c2_ack", 32'(dbg_ack), 32'd0);
    tick();
    chk("csr_c3_ack", 32'(dbg_ack), 32'd1);
    chk("csr_c3_err", 32'(dbg_err), 32'd0);
    dbg_req = 1'b0;
    tick();
    chk("csr_wen", 32'(wen_cnt - w0), 32'd1);
    dbg_we = 1'b0; dbg_req = 1'b1;
    tick(4);
    chk("csr_rd_ack", 32'(dbg_ack), 32'd1);
    chk("csr_rdata", dbg_rdata, 32'h5);
`else
    chk("csr_c2_ack", 32'(dbg_ack), 32'd1);
    chk("csr_c2_err", 32'(dbg_err), 32'd1);
    chk("csr_rdata_kept", dbg_rdata, 32'h11);
    dbg_req = 1'b0;
    tick();
    chk("csr_no_wen", 32'(wen_cnt - w0), 32'd0);
`endif
    dbg_req = 1'b0;
    tick();
    // reset during RD_DATA
    dbg_we = 1'b0; dbg_addr = 6'd5; dbg_req = 1'b1;
    tick(3);
    chk("rst_rd_c3_ack", 32'(dbg_ack), 32'd0);
    chk("rst_rd_c3_hold", 32'(core_hold), 32'd1);
    reset = 1'b0; dbg_req = 1'b0;
    tick();
    chk("rst_mid_hold", 32'(core_hold), 32'd0);
    chk("rst_mid_ack", 32'(dbg_ack), 32'd0);
    chk("rst_mid_rdata", dbg_rdata, 32'd0);
    chk("rst_mid_err", 32'(dbg_err), 32'd0);
    reset = 1'b1;
    tick();
    chk("post_rst_hold", 32'(core_hold), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fwrisc_regfile_dbg_arb.md
Name: fwrisc_regfile_dbg_arb

Overview:
Shares the 64-entry fwrisc register file (GPRs 0-31, CSR shadow 32-63) between the core and a debug requester, such as the UART debug bridge. The block sits between the core's regfile address/write signals and fwrisc_regfile. A debug request first stalls the core, then waits for the core to quiesce. It then performs one debug read or write, accounting for the regfile's 1-cycle registered-address read latency, and finally releases the core through a four-phase handshake.

Parameters:
HOLD_TIMEOUT, 255, max cycles spent in HOLD waiting for quiesce before aborting with error (>=2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
core_ra_raddr  in  6  core port-A read address
core_rb_raddr  in  6  core port-B read address
core_rd_waddr  in  6  core write address
core_rd_wdata  in  32  core write data
core_rd_wen  in  1  core write enable
core_quiesce  in  1  core idle at instruction boundary while held
core_hold  out  1  stall request to core
dbg_req  in  1  debug request, level; addr/we/wdata stable while high
dbg_we  in  1  1=write, 0=read
dbg_addr  in  6  debug register index
dbg_wdata  in  32  debug write data
dbg_ack  out  1  transaction done; high until dbg_req drops
dbg_err  out  1  valid with dbg_ack: timeout or illegal address
dbg_rdata  out  32  read data, valid with dbg_ack
rf_ra_raddr  out  6  to regfile ra_raddr
rf_rb_raddr  out  6  to regfile rb_raddr
rf_rd_waddr  out  6  to regfile rd_waddr
rf_rd_wdata  out  32  to regfile rd_wdata
rf_rd_wen  out  1  to regfile rd_wen
rf_ra_rdata  in  32  from regfile ra_rdata

Behaviour:
- Reset (reset==0 at posedge): state IDLE, timeout counter 0, dbg_rdata 0, dbg_err 0. In IDLE, core_hold=0, dbg_ack=0, and the rf_* outputs pass the core signals through. Reset mid-transaction aborts it: no write issued, no ack.
- States: IDLE, HOLD, RD_ADDR, RD_DATA, WR, ACK. State is registered; all outputs decode from state and registers only.
- IDLE: rf_* = core_*. If dbg_req -> HOLD, counter cleared.
- HOLD: core_hold=1; rf_* still pass the core signals so in-flight writes drain. Counter increments each cycle.
  - Grant when core_quiesce && !core_rd_wen: go to WR if dbg_we, else RD_ADDR.
  - Illegal address (see Optional Feature): go to ACK with dbg_err=1, no access.
  - Counter == HOLD_TIMEOUT-1 with no grant: go to ACK with dbg_err=1.
  - Grant takes priority over timeout in the same cycle.
- RD_ADDR: rf_ra_raddr=dbg_addr; core_rd_wen blocked (rf_rd_wen=0) -> RD_DATA.
- RD_DATA: rf_ra_raddr=dbg_addr; dbg_rdata <= rf_ra_rdata; dbg_err <= 0 -> ACK.
- WR: rf_rd_waddr=dbg_addr, rf_rd_wdata=dbg_wdata, rf_rd_wen=1 (0 if dbg_addr==0; x0 is never written); dbg_err <= 0 -> ACK.
- ACK: dbg_ack=1, core_hold=1. Stay while dbg_req=1; when dbg_req=0 -> IDLE, which releases core_hold.
- rf_rb_raddr always = core_rb_raddr.
- In RD_ADDR, RD_DATA, WR and ACK the core write is blocked. Core writes in those states are a protocol violation: ignored, no assertion fires.
- Latency, quiesce already high, req rises in cycle 0:
  - Read: ACK in cycle 4.
  - Write: rf_rd_wen in cycle 2, ACK in cycle 3.
- Read of x0 returns 0, because the regfile forces it.

Optional Feature:
FWRISC_REGFILE_DBG_CSR_EN.
- Defined: all 64 addresses accessible.
- Undefined: dbg_addr[5]==1 is illegal. HOLD goes to ACK with dbg_err=1 on its first cycle, with no regfile access and dbg_rdata unchanged.

Decomposition:
- fwrisc_regfile_dbg_pkg: state enum (dbg_arb_state_e) and constants REGFILE_AW=6, REGFILE_DW=32, GPR_LAST=31.
- Sub-module fwrisc_regfile_dbg_timeout: HOLD counter with clear/enable/expired, width $clog2(HOLD_TIMEOUT).

Test Plan:
- Write x5=0xDEADBEEF, quiesce=1 -> rf_rd_wen pulse cycle 2 with waddr 5; ack cycle 3, err 0; core_hold low the cycle after req drops.
- Then read x5 -> ack cycle 4, dbg_rdata=0xDEADBEEF. Read x0 after a debug write to x0 -> rf_rd_wen never high, rdata=0.
- Hold with core_rd_wen=1 writing x7=0x11 for 3 cycles, quiesce=1 throughout -> core writes reach regfile, grant only after core_rd_wen drops; debug read x7 returns 0x11.
- quiesce stuck 0, HOLD_TIMEOUT=8 -> ack with dbg_err=1 exactly 8 cycles after entering HOLD, no rf_rd_wen.
- dbg_addr=0x21 write 0x5: with macro -> written, readback 0x5; without -> dbg_err=1, no write.
- reset low during RD_DATA -> next cycle IDLE, core_hold=0, dbg_ack=0, dbg_rdata=0.
